// File: rtl/dea_pkg.sv
// Shared constants, width derivations and mode encoding for the dea_stream XOR cipher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dea_pkg;

    localparam int DEA_DATA_W   = 8;
    localparam int DEA_MAX_KEYS = 4;

    typedef enum logic {
        MODE_KEY  = 1'b0,
        MODE_DATA = 1'b1
    } mode_e;

    // num_keys must represent 0..max_keys inclusive.
    function automatic int dea_cnt_w(input int max_keys);
        return $clog2(max_keys + 1);
    endfunction

    // Key index needs at least one bit even for a single-entry bank.
    function automatic int dea_idx_w(input int max_keys);
        return (max_keys > 1) ? $clog2(max_keys) : 1;
    endfunction

endpackage

// File: rtl/dea_key_bank.sv
// Key storage with saturating fill counter, sticky overflow flag and kset rising-edge detect.
// Latency: writes land on the next rising edge; the read port is combinational from i_rd_idx.
// Backpressure: never stalls; writes into a full bank are dropped and flagged on o_key_ovf.
// Ports: i_clk/i_rst_n; i_kset, i_wr_vld, i_wr_dat (write side); i_rd_idx -> o_key_word;
//        o_num_keys, o_key_ovf status; o_kset_rise marks the first cycle of a key load.
module dea_key_bank
    import dea_pkg::*;
#(
    parameter int DATA_W   = DEA_DATA_W,
    parameter int MAX_KEYS = DEA_MAX_KEYS,
    parameter int CNT_W    = dea_cnt_w(MAX_KEYS),
    parameter int IDX_W    = dea_idx_w(MAX_KEYS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_kset,
    input  logic              i_wr_vld,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_key_word,
    output logic [CNT_W-1:0]  o_num_keys,
    output logic              o_key_ovf,
    output logic              o_kset_rise
);

    logic [DATA_W-1:0] r_keys [MAX_KEYS];
    logic [CNT_W-1:0]  r_num_keys;
    logic              r_key_ovf;
    logic              r_kset_d;

    logic              w_kset_rise;
    logic              w_full;
    logic [IDX_W-1:0]  w_wr_idx;

    assign w_kset_rise = i_kset & ~r_kset_d;
    assign w_full      = (r_num_keys == CNT_W'(MAX_KEYS));
    // Only used when the bank is not full, so num_keys always fits the index width.
    assign w_wr_idx    = IDX_W'(r_num_keys);

    assign o_key_word  = r_keys[i_rd_idx];
    assign o_num_keys  = r_num_keys;
    assign o_key_ovf   = r_key_ovf;
    assign o_kset_rise = w_kset_rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kset_d   <= 1'b0;
            r_num_keys <= '0;
            r_key_ovf  <= 1'b0;
            for (int i = 0; i < MAX_KEYS; i++) begin
                r_keys[i] <= '0;
            end
        end else begin
            r_kset_d <= i_kset;
            if (w_kset_rise) begin
                // New key load restarts the bank; a beat on this same cycle is slot 0.
                r_key_ovf <= 1'b0;
                if (i_wr_vld) begin
                    r_keys[0]  <= i_wr_dat;
                    r_num_keys <= CNT_W'(1);
                end else begin
                    r_num_keys <= '0;
                end
            end else if (i_kset && i_wr_vld) begin
                if (w_full) begin
                    r_key_ovf <= 1'b1;
                end else begin
                    r_keys[w_wr_idx] <= i_wr_dat;
                    r_num_keys       <= r_num_keys + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dea_stream.sv
// Repeating-key XOR stream cipher: keys loaded serially while kset=1, data XORed round-robin when kset=0.
// Latency: 1 cycle from accepted input beat to out_valid; full throughput through a single output register.
// Backpressure: in_ready drops while the output register is held (out_valid && !out_ready) or no keys are loaded.
// Ports: dclk/reset; kset, in_valid, in_sof, din -> in_ready; dout, out_valid <- out_ready; num_keys, key_ovf status.
module dea_stream
    import dea_pkg::*;
#(
    parameter int DATA_W   = DEA_DATA_W,
    parameter int MAX_KEYS = DEA_MAX_KEYS,
    parameter int CNT_W    = dea_cnt_w(MAX_KEYS),
    parameter int IDX_W    = dea_idx_w(MAX_KEYS)
) (
    input  logic              dclk,
    input  logic              reset,
    input  logic              kset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] din,
    output logic              in_ready,
    output logic [DATA_W-1:0] dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  num_keys,
    output logic              key_ovf
);

    mode_e             w_mode;
    logic              w_accept;
    logic              w_kset_rise;
    logic              w_last;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [DATA_W-1:0] w_key_word;
    logic [CNT_W-1:0]  w_num_keys;

    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_dout;
    logic              r_out_valid;

    assign w_mode = kset ? MODE_KEY : MODE_DATA;

    // Key mode always accepts; data mode needs keys and room in the output register.
    assign in_ready = (w_mode == MODE_KEY) ? 1'b1
                    : ((w_num_keys != '0) && (!r_out_valid || out_ready));
    assign w_accept = (w_mode == MODE_DATA) && in_valid && in_ready;

    // Start of frame rewinds to key 0 for this beat.
    assign w_rd_idx = in_sof ? '0 : r_idx;
    assign w_last   = (CNT_W'(r_idx) == (w_num_keys - CNT_W'(1)));

    always_comb begin
        w_idx_next = r_idx;
        if (in_sof) begin
            w_idx_next = (w_num_keys == CNT_W'(1)) ? '0 : IDX_W'(1);
        end else begin
            w_idx_next = w_last ? '0 : (r_idx + IDX_W'(1));
        end
    end

    dea_key_bank #(
        .DATA_W   (DATA_W),
        .MAX_KEYS (MAX_KEYS),
        .CNT_W    (CNT_W),
        .IDX_W    (IDX_W)
    ) u_key_bank (
        .i_clk       (dclk),
        .i_rst_n     (reset),
        .i_kset      (kset),
        .i_wr_vld    (in_valid),
        .i_wr_dat    (din),
        .i_rd_idx    (w_rd_idx),
        .o_key_word  (w_key_word),
        .o_num_keys  (w_num_keys),
        .o_key_ovf   (key_ovf),
        .o_kset_rise (w_kset_rise)
    );

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            r_idx       <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_kset_rise) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= w_idx_next;
            end

            // kset does not flush: a held beat drains only through out_ready.
            if (w_accept) begin
                r_dout      <= din ^ w_key_word;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_out_valid;
    assign num_keys  = w_num_keys;

endmodule

// File: tb/tb_dea_stream.sv
module tb_dea_stream;

    localparam int DW    = 8;
    localparam int MAXK  = 4;
    localparam int CNTW  = 3;

    logic            dclk;
    logic            reset;
    logic            kset;
    logic            in_valid;
    logic            in_sof;
    logic [DW-1:0]   din;
    logic            in_ready;
    logic [DW-1:0]   dout;
    logic            out_valid;
    logic            out_ready;
    logic [CNTW-1:0] num_keys;
    logic            key_ovf;

    dea_stream #(.DATA_W(DW), .MAX_KEYS(MAXK)) dut (
        .dclk      (dclk),
        .reset     (reset),
        .kset      (kset),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .din       (din),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .num_keys  (num_keys),
        .key_ovf   (key_ovf)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;

    // Reference model: the key list as loaded, the beat position within the frame,
    // and whether an output beat is currently held.
    logic [DW-1:0] m_keys[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf   = 1'b0;
    bit            m_ov    = 1'b0;
    bit            m_kprev = 1'b0;
    int            m_pos   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a transfer completes at the next rising edge when both are high.
    always @(negedge dclk) begin
        if (armed && reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dout_unexpected: actual 0x%0h with no beat expected at %0t", dout, $time);
            end else begin
                chk("dout", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic k, input logic v, input logic s,
                         input logic [DW-1:0] d, input logic ordy);
        bit exp_rdy;
        bit acc;
        int sel;
        kset = k; in_valid = v; in_sof = s; din = d; out_ready = ordy;
        @(negedge dclk);
        chk("num_keys", int'(num_keys), m_keys.size());
        chk("key_ovf", int'(key_ovf), int'(m_ovf));
        chk("out_valid", int'(out_valid), int'(m_ov));
        exp_rdy = k ? 1'b1 : ((m_keys.size() != 0) && (!m_ov || ordy));
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        acc = 1'b0;
        if (k) begin
            if (!m_kprev) begin
                m_keys.delete();
                m_ovf = 1'b0;
                m_pos = 0;
            end
            if (v) begin
                if (m_keys.size() < MAXK) m_keys.push_back(d);
                else m_ovf = 1'b1;
            end
        end else if (v && exp_rdy) begin
            sel = s ? 0 : (m_pos % m_keys.size());
            exp_q.push_back(d ^ m_keys[sel]);
            m_pos = s ? 1 : m_pos + 1;
            acc = 1'b1;
        end
        m_ov    = acc || (m_ov && !ordy);
        m_kprev = k;
        @(posedge dclk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        kset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_num_keys", int'(num_keys), 0);
        chk("rst_key_ovf", int'(key_ovf), 0);
        #1;
        reset = 1'b1;
        m_keys.delete();
        exp_q.delete();
        m_ovf = 1'b0; m_ov = 1'b0; m_kprev = 1'b0; m_pos = 0;
        @(posedge dclk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nk;
        int loaded;
        int nb;
        bit v;
        reset = 1'b1; kset = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        din = '0; out_ready = 1'b0;
        @(posedge dclk);
        #1;
        do_reset();
        armed = 1'b1;

        // Three keys, five zero beats: 11,22,33,11,22.
        cycle(1, 1, 0, 8'h11, 1);
        cycle(1, 1, 0, 8'h22, 1);
        cycle(1, 1, 0, 8'h33, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 1);

        // Backpressure holds 5A and freezes the key position.
        cycle(1, 1, 0, 8'hA5, 1);
        cycle(1, 1, 0, 8'h5A, 1);
        cycle(0, 1, 0, 8'hFF, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'hFF, 0);
        cycle(0, 1, 0, 8'hFF, 1);
        cycle(0, 0, 0, 8'h00, 1);

        // Start of frame rewinds to key 0.
        cycle(1, 1, 0, 8'h01, 1);
        cycle(1, 1, 0, 8'h02, 1);
        cycle(1, 1, 0, 8'h04, 1);
        cycle(1, 1, 0, 8'h08, 1);
        cycle(0, 1, 0, 8'h00, 1);
        cycle(0, 1, 0, 8'h00, 1);
        cycle(0, 1, 1, 8'h00, 1);
        cycle(0, 1, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 1);

        // Overflow: fifth key dropped, flag cleared by the next key load.
        for (int i = 1; i <= 5; i++) cycle(1, 1, 0, 8'(i * 16), 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 1);

        // No keys after reset: data stalls.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 8'h77, 1);

        // Reset while an output beat is held, then stall until keys return.
        cycle(1, 1, 0, 8'h3C, 1);
        cycle(0, 1, 0, 8'hC3, 0);
        cycle(0, 1, 0, 8'h01, 0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'h42, 1);
        cycle(1, 1, 0, 8'h99, 1);
        cycle(0, 1, 0, 8'h42, 1);

        // Randomized rounds: key loads (possibly overflowing or empty), bursty data,
        // random backpressure, sof and occasional resets.
        for (int r = 0; r < 40; r++) begin
            nk = $urandom_range(0, 6);
            cycle(1, 0, 0, 8'h00, 1'($urandom_range(0, 1)));
            loaded = 0;
            while (loaded < nk) begin
                v = ($urandom_range(0, 3) != 0);
                cycle(1, v, 0, 8'($urandom), 1'($urandom_range(0, 1)));
                if (v) loaded++;
            end
            nb = $urandom_range(10, 50);
            for (int b = 0; b < nb; b++) begin
                cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                      8'($urandom), ($urandom_range(0, 3) != 0));
            end
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dea_stream.md
Name: dea_stream

Overview:
Parametrised repeating-key XOR stream cipher with a valid/ready handshake on both sides.
- Keys are loaded serially over the shared `din` bus while `kset` is high.
- Data beats are then XORed with the keys in round-robin order, one beat per accepted transfer.
- Successor to the fixed 8-bit, 4-key encryptor: it adds parametrised width and depth, backpressure, frame restart and key-overflow reporting.
- Sits between the byte/word source and the downstream packer; the same block decrypts, because XOR is symmetric.

Parameters:
DATA_W, 8, width of data and of each key word
MAX_KEYS, 4, key bank depth (>=1)
CNT_W, $clog2(MAX_KEYS+1), width of num_keys (derived, do not override)
IDX_W, max(1,$clog2(MAX_KEYS)), width of key index (derived)

Ports:
dclk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
kset  in  1  1 = key-load mode, 0 = data mode
in_valid  in  1  din beat valid
in_sof  in  1  start of frame, qualified by in_valid in data mode
din  in  DATA_W  key word (kset=1) or plaintext/ciphertext (kset=0)
in_ready  out  1  beat accepted when in_valid&&in_ready
dout  out  DATA_W  XOR result
out_valid  out  1  dout valid
out_ready  in  1  downstream accepts dout
num_keys  out  CNT_W  keys currently loaded (0..MAX_KEYS)
key_ovf  out  1  sticky: key write attempted with bank full

Behaviour:
- Reset (reset=0, async):
  - dout=0, out_valid=0, num_keys=0, key_ovf=0.
  - Key index idx=0; key bank cleared to 0.
  - Applies immediately, including mid-transfer; a held output beat is discarded.
- kset rising edge (kset=1, registered kset_d=0):
  - num_keys, key_ovf and idx clear to 0 on that edge.
  - A beat with in_valid=1 on the same cycle is written to slot 0, and num_keys becomes 1.
- Key load (kset=1):
  - in_ready=1 always.
  - Each accepted beat writes keys[num_keys] <= din and increments num_keys.
  - When num_keys==MAX_KEYS, the write is dropped, num_keys holds and key_ovf <= 1. key_ovf stays set until reset or the next kset rising edge.
- kset=1 never alters a pending output beat. out_valid/dout hold until out_ready, so kset does not flush.
- Data mode (kset=0):
  - in_ready = (num_keys!=0) && (!out_valid || out_ready). Single output register, full throughput, no combinational path from in_valid to out_valid.
  - On accept without in_sof:
    - dout <= din ^ keys[idx]; out_valid <= 1.
    - idx <= (idx==num_keys-1) ? 0 : idx+1.
  - On accept with in_sof=1: key 0 is used regardless of idx, and idx <= (num_keys==1) ? 0 : 1.
  - Output handshake: if out_valid && out_ready && no accept, out_valid <= 0.
  - Latency: 1 cycle from accept to out_valid.
  - No accept means no idx change; backpressure never skips or repeats a key.
- num_keys==0 in data mode: in_ready=0 and beats stall. There is no pass-through.
- kset falling edge: idx is already 0 from the preceding rising edge, so the first data beat uses key 0.
- Width rule: the XOR is bitwise at DATA_W with no truncation. num_keys saturates at MAX_KEYS and never wraps.

Decomposition:
- Package dea_pkg holds:
  - default DATA_W/MAX_KEYS constants;
  - the CNT_W/IDX_W derivation function;
  - a mode enum {MODE_KEY, MODE_DATA}.
- Sub-module dea_key_bank holds:
  - the key storage array and the num_keys counter;
  - saturation and key_ovf logic;
  - the kset edge detect.
  - Interface: write port plus read address idx, read data key_word.
- dea_stream keeps idx, the handshake and the output register.

Test Plan:
1. Load 0x11,0x22,0x33 (kset=1), then data 0x00 x5 with out_ready=1 -> dout 0x11,0x22,0x33,0x11,0x22 on consecutive cycles; num_keys=3.
2. Keys 0xA5,0x5A; data 0xFF; out_ready=0 for 3 cycles -> dout=0x5A held with out_valid=1, in_ready=0, idx unchanged; on release the next beat 0xFF gives 0xA5.
3. Keys 0x01,0x02,0x04,0x08; data 0x00,0x00, then 0x00 with in_sof=1 -> dout 0x01,0x02,0x01, and the following beat gives 0x02.
4. With MAX_KEYS=4, load 5 keys 0x10..0x50 -> num_keys=4, key_ovf=1, and slot 0x50 dropped (data 0x00 cycles 0x10..0x40). Re-raise kset -> key_ovf=0, num_keys=0.
5. After reset, kset=0, in_valid=1, din=0x77 -> in_ready=0 and out_valid stays 0 for 10 cycles.
6. Mid-stream with out_valid=1, pulse reset low between edges -> dout=0, out_valid=0, num_keys=0 immediately (asynchronous); after release the first data beat stalls until keys are reloaded.
